// File: rtl/lt_sequencer_pkg.sv
// Shared encodings for the latency tester: test-patch positions and sequencer states.
package lt_sequencer_pkg;

    typedef enum logic [1:0] {
        LT_NONE         = 2'd0,
        LT_TOP_LEFT     = 2'd1,
        LT_CENTER       = 2'd2,
        LT_BOTTOM_RIGHT = 2'd3
    } lt_mode_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_SHOW    = 2'd2,
        ST_RELEASE = 2'd3
    } lt_state_t;

    localparam logic [15:0] LINE_MAX = 16'hFFFF;

endpackage

// File: rtl/lt_sync2.sv
// Two-flop synchronizer for a single asynchronous level, with selectable reset value.
module lt_sync2 #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk27,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic meta_p0;
    logic sync_p1;

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            meta_p0 <= RESET_VAL;
            sync_p1 <= RESET_VAL;
        end else begin
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/lt_sequencer.sv
// Latency-test sequencer: shows a test patch, counts HSYNC periods until the
// photodiode fires, and reports the result or a timeout.
module lt_sequencer
    import lt_sequencer_pkg::*;
#(
    parameter logic [7:0] TIMEOUT_FRAMES = 8'd60
) (
    input  logic        clk27,
    input  logic        reset_n,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        trigger_n,
    input  logic        sensor_in,
    input  logic [1:0]  mode_sel,
    output logic        lt_active,
    output logic [1:0]  lt_mode,
    output logic        busy,
    output logic [15:0] result_lines,
    output logic        result_valid,
    output logic        timeout
);

    logic      trig_s;
    logic      sensor_s;
    logic      trig_q;
    logic      hs_q;
    logic      vs_q;
    logic      trig_fall;
    logic      hs_fall;
    logic      vs_fall;
    lt_state_t state;
    lt_mode_t  mode_lat;
    logic [15:0] line_cnt;
    logic [15:0] line_next;
    logic [7:0]  frame_cnt;
    logic [7:0]  frame_next;

    lt_sync2 #(.RESET_VAL(1'b1)) u_sync_trig (
        .clk27   (clk27),
        .reset_n (reset_n),
        .d       (trigger_n),
        .q       (trig_s)
    );

    lt_sync2 #(.RESET_VAL(1'b0)) u_sync_sensor (
        .clk27   (clk27),
        .reset_n (reset_n),
        .d       (sensor_in),
        .q       (sensor_s)
    );

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            trig_q <= 1'b1;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
        end else begin
            trig_q <= trig_s;
            hs_q   <= hsync_in;
            vs_q   <= vsync_in;
        end
    end

    assign trig_fall = trig_q & ~trig_s;
    assign hs_fall   = hs_q & ~hsync_in;
    assign vs_fall   = vs_q & ~vsync_in;

    // Line count saturates so a very late detection never reads as a short one.
    always_comb begin
        line_next = line_cnt;
        if (hs_fall && line_cnt != LINE_MAX) begin
            line_next = line_cnt + 16'd1;
        end
        frame_next = vs_fall ? frame_cnt + 8'd1 : frame_cnt;
    end

    always_ff @(posedge clk27 or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            mode_lat     <= LT_NONE;
            lt_active    <= 1'b0;
            lt_mode      <= LT_NONE;
            result_lines <= 16'd0;
            result_valid <= 1'b0;
            timeout      <= 1'b0;
            line_cnt     <= 16'd0;
            frame_cnt    <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    lt_active <= 1'b0;
                    lt_mode   <= LT_NONE;
                    if (trig_fall && mode_sel != 2'b00) begin
                        mode_lat     <= lt_mode_t'(mode_sel);
                        result_valid <= 1'b0;
                        timeout      <= 1'b0;
                        state        <= ST_ARM;
                    end
                end
                // A lit sensor here would mean ambient light, so wait until it is dark.
                ST_ARM: begin
                    if (vs_fall && !sensor_s) begin
                        line_cnt  <= 16'd0;
                        frame_cnt <= 8'd0;
                        lt_active <= 1'b1;
                        lt_mode   <= mode_lat;
                        state     <= ST_SHOW;
                    end
                end
                ST_SHOW: begin
                    if (sensor_s) begin
                        result_lines <= line_next;
                        result_valid <= 1'b1;
                        lt_active    <= 1'b0;
                        lt_mode      <= LT_NONE;
                        state        <= ST_RELEASE;
                    end else if (frame_cnt == TIMEOUT_FRAMES) begin
                        timeout   <= 1'b1;
                        lt_active <= 1'b0;
                        lt_mode   <= LT_NONE;
                        state     <= ST_RELEASE;
                    end else begin
                        line_cnt  <= line_next;
                        frame_cnt <= frame_next;
                    end
                end
                ST_RELEASE: begin
                    lt_active <= 1'b0;
                    lt_mode   <= LT_NONE;
                    if (vs_fall && !sensor_s) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_lt_sequencer.sv
// Directed and randomized bench for lt_sequencer using a compact video timing generator.
module tb_lt_sequencer;

    localparam int LINE_CLKS   = 8;
    localparam int FRAME_LINES = 128;
    localparam int WAIT_BOUND  = 4 * LINE_CLKS * FRAME_LINES;

    logic        clk27 = 1'b0;
    logic        reset_n = 1'b0;
    logic        hsync_in = 1'b1;
    logic        vsync_in = 1'b1;
    logic        trigger_n = 1'b1;
    logic        sensor_in = 1'b0;
    logic [1:0]  mode_sel = 2'd0;
    logic        lt_active;
    logic [1:0]  lt_mode;
    logic        busy;
    logic [15:0] result_lines;
    logic        result_valid;
    logic        timeout;

    int total = 0;
    int bad = 0;
    int hs_count = 0;
    int vs_count = 0;

    // Expected result registers, updated from the measurement rules.
    int exp_lines = 0;
    int exp_valid = 0;
    int exp_tout  = 0;

    lt_sequencer #(.TIMEOUT_FRAMES(8'd2)) dut (
        .clk27        (clk27),
        .reset_n      (reset_n),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .trigger_n    (trigger_n),
        .sensor_in    (sensor_in),
        .mode_sel     (mode_sel),
        .lt_active    (lt_active),
        .lt_mode      (lt_mode),
        .busy         (busy),
        .result_lines (result_lines),
        .result_valid (result_valid),
        .timeout      (timeout)
    );

    always #5 clk27 = ~clk27;

    // Video timing: HSYNC low for 2 clocks per line, VSYNC falls mid-line on line 0.
    initial begin : video
        int pix;
        int line;
        pix = 0;
        line = 0;
        forever begin
            @(posedge clk27);
            #2;
            hsync_in = (pix < 2) ? 1'b0 : 1'b1;
            vsync_in = (line == 0 && pix >= 4) ? 1'b0 : 1'b1;
            if (pix == 0) hs_count++;
            if (line == 0 && pix == 4) vs_count++;
            pix++;
            if (pix == LINE_CLKS) begin
                pix = 0;
                line = (line + 1) % FRAME_LINES;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk27);
    endtask

    task automatic wait_vs(input int n);
        int target;
        int guard;
        target = vs_count + n;
        guard = 0;
        while (vs_count < target && guard < WAIT_BOUND * n) begin
            @(negedge clk27);
            guard++;
        end
        if (vs_count < target) begin
            total++;
            bad++;
            $error("FAIL vs_wait observed=%0d expected=%0d", vs_count, target);
        end
    endtask

    task automatic wait_hs_until(input int target);
        int guard;
        guard = 0;
        while (hs_count < target && guard < WAIT_BOUND) begin
            @(negedge clk27);
            guard++;
        end
        if (hs_count < target) begin
            total++;
            bad++;
            $error("FAIL hs_wait observed=%0d expected=%0d", hs_count, target);
        end
    endtask

    task automatic pulse_trigger();
        trigger_n = 1'b0;
        tick(4);
        trigger_n = 1'b1;
        tick(4);
    endtask

    // Trigger right after a VSYNC so the request is armed well before the next one.
    task automatic start_arm(input logic [1:0] mode);
        wait_vs(1);
        tick(2);
        mode_sel = mode;
        pulse_trigger();
        exp_valid = 0;
        exp_tout = 0;
        chk("arm_busy", 32'(busy), 32'd1);
        chk("arm_active", 32'(lt_active), 32'd0);
        chk("arm_valid_clr", 32'(result_valid), 32'(exp_valid));
    endtask

    task automatic enter_show(input logic [1:0] mode, output int hs_base);
        wait_vs(1);
        hs_base = hs_count;
        tick(2);
        chk("show_active", 32'(lt_active), 32'd1);
        chk("show_mode", 32'(lt_mode), 32'(mode));
    endtask

    task automatic detect(input int hs_base, input int k);
        wait_hs_until(hs_base + k);
        tick(1);
        sensor_in = 1'b1;
        tick(6);
        exp_lines = k;
        exp_valid = 1;
        exp_tout = 0;
        chk("det_lines", 32'(result_lines), 32'(exp_lines));
        chk("det_valid", 32'(result_valid), 32'(exp_valid));
        chk("det_timeout", 32'(timeout), 32'(exp_tout));
        chk("det_active", 32'(lt_active), 32'd0);
        chk("det_mode", 32'(lt_mode), 32'd0);
        chk("det_busy", 32'(busy), 32'd1);
        sensor_in = 1'b0;
        if (k < 120) begin
            tick(6);
            chk("rel_hold_busy", 32'(busy), 32'd1);
        end
        wait_vs(1);
        tick(2);
        chk("rel_idle_busy", 32'(busy), 32'd0);
        chk("rel_keep_lines", 32'(result_lines), 32'(exp_lines));
    endtask

    task automatic measure(input logic [1:0] mode, input int k, input bit second_trig);
        int hs_base;
        start_arm(mode);
        enter_show(mode, hs_base);
        if (second_trig) begin
            tick(16);
            pulse_trigger();
            chk("retrig_active", 32'(lt_active), 32'd1);
            chk("retrig_mode", 32'(lt_mode), 32'(mode));
        end
        detect(hs_base, k);
    endtask

    initial begin : main
        int hs_base;
        int prev_lines;
        logic [1:0] rmode;
        int rk;
        bit rsec;

        // Reset state
        tick(5);
        chk("rst_active", 32'(lt_active), 32'd0);
        chk("rst_mode", 32'(lt_mode), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_lines", 32'(result_lines), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        reset_n = 1'b1;
        tick(3);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Trigger with no patch selected is ignored
        wait_vs(1);
        tick(2);
        mode_sel = 2'd0;
        pulse_trigger();
        for (int i = 0; i < 8; i++) begin
            tick(150);
            chk("mode0_busy", 32'(busy), 32'd0);
            chk("mode0_active", 32'(lt_active), 32'd0);
        end

        // Centre patch, detection after 100 lines
        measure(2'd2, 100, 1'b0);

        // Re-trigger during SHOW must not disturb the measurement
        measure(2'd1, 40, 1'b1);

        // Randomized measurements
        for (int i = 0; i < 4; i++) begin
            rmode = 2'($urandom_range(1, 3));
            rk = int'($urandom_range(8, 200));
            rsec = 1'($urandom_range(0, 1));
            measure(rmode, rk, rsec);
        end

        // Sensor lit during ARM holds off SHOW until it clears
        sensor_in = 1'b1;
        start_arm(2'd3);
        wait_vs(1);
        tick(2);
        chk("lit_arm_active", 32'(lt_active), 32'd0);
        chk("lit_arm_busy", 32'(busy), 32'd1);
        sensor_in = 1'b0;
        tick(6);
        chk("dark_wait_active", 32'(lt_active), 32'd0);
        enter_show(2'd3, hs_base);
        detect(hs_base, 5);

        // Timeout after two frames with no detection
        prev_lines = exp_lines;
        start_arm(2'd1);
        enter_show(2'd1, hs_base);
        wait_vs(2);
        tick(3);
        exp_tout = 1;
        exp_valid = 0;
        chk("to_timeout", 32'(timeout), 32'(exp_tout));
        chk("to_valid", 32'(result_valid), 32'(exp_valid));
        chk("to_active", 32'(lt_active), 32'd0);
        chk("to_mode", 32'(lt_mode), 32'd0);
        chk("to_busy", 32'(busy), 32'd1);
        chk("to_lines", 32'(result_lines), 32'(prev_lines));
        wait_vs(1);
        tick(2);
        chk("to_idle_busy", 32'(busy), 32'd0);
        chk("to_hold_timeout", 32'(timeout), 32'd1);

        // Reset in the middle of SHOW
        start_arm(2'd2);
        enter_show(2'd2, hs_base);
        tick(10);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_active", 32'(lt_active), 32'd0);
        chk("async_rst_busy", 32'(busy), 32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(2);
        exp_lines = 0;
        exp_valid = 0;
        exp_tout = 0;
        chk("rel_rst_active", 32'(lt_active), 32'd0);
        chk("rel_rst_mode", 32'(lt_mode), 32'd0);
        chk("rel_rst_busy", 32'(busy), 32'd0);
        chk("rel_rst_lines", 32'(result_lines), 32'(exp_lines));
        chk("rel_rst_valid", 32'(result_valid), 32'(exp_valid));
        chk("rel_rst_timeout", 32'(timeout), 32'(exp_tout));
        wait_vs(1);
        tick(2);
        chk("rel_rst_stay_idle", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lt_sequencer.md
LT_SEQUENCER -- requirements
Module: lt_sequencer

Interface
REQ-001 Parameter TIMEOUT_FRAMES, default 8'd60: number of VSYNC falling edges in SHOW before a measurement is abandoned.
REQ-002 clk27  input  1  single pixel clock (27 MHz); all logic on its rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 hsync_in  input  1  negative-polarity HSYNC, synchronous to clk27.
REQ-005 vsync_in  input  1  negative-polarity VSYNC, synchronous to clk27.
REQ-006 trigger_n  input  1  asynchronous active-low start button.
REQ-007 sensor_in  input  1  asynchronous active-high photodiode detect.
REQ-008 mode_sel  input  2  requested test-patch position (LT mode encoding).
REQ-009 lt_active  output  1  drives the video generator's latency-test enable.
REQ-010 lt_mode  output  2  drives the video generator's test-patch position.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 result_lines  output  16  measured latency in HSYNC periods.
REQ-013 result_valid  output  1  high while result_lines holds a completed measurement.
REQ-014 timeout  output  1  high while the last attempt ended without detection.

Function
REQ-015 trigger_n and sensor_in each pass through a 2-flop synchronizer; trigger falling edge and sensor level are taken from synchronized values only.
REQ-016 HSYNC/VSYNC falling edges are detected against a one-cycle registered copy; an edge flag is valid in the cycle after the input falls.
REQ-017 FSM states: IDLE, ARM, SHOW, RELEASE; encoding fixed in the shared include.
REQ-018 IDLE: lt_active=0; a trigger falling edge with mode_sel!=0 latches mode_sel, clears result_valid and timeout, and moves to ARM; with mode_sel==0 the edge is ignored.
REQ-019 ARM: on a VSYNC edge with synchronized sensor low, clear line and frame counters and move to SHOW; with sensor high, remain in ARM.
REQ-020 SHOW: lt_active=1 and lt_mode=latched mode, registered, first asserted in the cycle after the ARM->SHOW transition edge flag.
REQ-021 SHOW: each HSYNC edge increments the 16-bit line counter; it saturates at 16'hFFFF with no wrap.
REQ-022 SHOW: each VSYNC edge increments the 8-bit frame counter.
REQ-023 SHOW with synchronized sensor high: result_lines <= line counter, including any increment in the same cycle; result_valid <= 1; move to RELEASE.
REQ-024 SHOW with frame counter == TIMEOUT_FRAMES and sensor low: timeout <= 1; result_lines is unchanged; move to RELEASE.
REQ-025 Sensor and timeout in the same cycle: sensor wins and timeout stays 0.
REQ-026 RELEASE: lt_active=0 and lt_mode=0; after synchronized sensor is low, the next VSYNC edge moves to IDLE.
REQ-027 Trigger edges outside IDLE are ignored, not queued.
REQ-028 In any state other than SHOW: lt_active=0 and lt_mode=2'b00.

Reset
REQ-029 While reset_n is low:
- state=IDLE
- all outputs 0
- counters 0
- trigger synchronizer flops 1, sensor synchronizer flops 0
- edge-detect registers 1
REQ-030 Reset asserted mid-SHOW drops lt_active asynchronously; no result is retained after release.

Structure
REQ-031 Shared include lat_tester_includes.v holds the LT mode encodings (0 none, 1 top-left, 2 center, 3 bottom-right) and the FSM state encodings.
REQ-032 One sub-module, lt_sync2 (1-bit 2-flop synchronizer, parameterized reset value), is instantiated for trigger_n and for sensor_in.

Verification
REQ-033 mode_sel=2, trigger pulse, sensor rises 100 HSYNC edges after SHOW entry -> lt_mode=2 during SHOW, result_lines=100, result_valid=1, timeout=0, busy falls after the next VSYNC edge.
REQ-034 TIMEOUT_FRAMES=2, trigger with mode_sel=1, sensor never high -> after 2 VSYNC edges: timeout=1, result_valid=0, lt_active=0, then IDLE.
REQ-035 mode_sel=0, trigger pulse -> busy stays 0 and lt_active stays 0.
REQ-036 Second trigger pulse during SHOW -> no state change; measurement completes normally.
REQ-037 Sensor held high through ARM -> no SHOW entry; release sensor -> SHOW at the next VSYNC edge.
REQ-038 reset_n low mid-SHOW -> lt_active=0 the same cycle; after release all outputs 0 and IDLE.
